// File: rtl/updown_counter_move_arbiter.sv
// Round-robin arbiter that steers one shared up/down counter to a granted target by the shortest path.
// Optional move timeout is enabled with `define MOVE_TIMEOUT_EN.
module updown_counter_move_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = (1 << WIDTH) + 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] tgt0_i,
    input  logic [WIDTH-1:0] tgt1_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic [1:0]       gnt_o,
    output logic             up_o,
    output logic             down_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o,
    output logic             err_o
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DONE} state_e;

    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic [WIDTH-1:0] tgt_q;
    logic             id_q;
    logic             ptr_q;
    logic [1:0]       gnt_q;

    logic [WIDTH-1:0] diff;
    logic             at_tgt;
    logic             go_up;
    logic             tmo;
    logic             win;

    assign diff   = tgt_q - cnt_i;
    assign at_tgt = (diff == '0);
    // A tie at exactly half the range is resolved upward.
    assign go_up  = (diff <= HALF);

    // Single requester wins outright; on contention the side not holding the pointer wins.
    always_comb begin
        win = ~ptr_q;
        if (req_i == 2'b01)
            win = 1'b0;
        else if (req_i == 2'b10)
            win = 1'b1;
    end

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q;
    logic          err_q;

    // timer_q counts MOVE cycles already spent, so this is the TIMEOUT-th MOVE cycle.
    assign tmo = (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req_i != 2'b00)
                timer_q <= '0;
            else if (state_q == S_MOVE)
                timer_q <= timer_q + TW'(1);
            if (state_q == S_MOVE)
                err_q <= !at_tgt && tmo;
        end
    end

    assign err_o = (state_q == S_DONE) && err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            gnt_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (req_i != 2'b00) begin
                        gnt_q   <= win ? 2'b10 : 2'b01;
                        id_q    <= win;
                        ptr_q   <= win;
                        tgt_q   <= win ? tgt1_i : tgt0_i;
                        state_q <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (at_tgt || tmo)
                        state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign up_o      = (state_q == S_MOVE) && !at_tgt && !tmo && go_up;
    assign down_o    = (state_q == S_MOVE) && !at_tgt && !tmo && !go_up;
    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign done_id_o = (state_q == S_DONE) && id_q;

endmodule
